wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid_a / in_valid_b  input  1  result A / B present this cycle; A is older than B.
REQ-005 SHALL have ports in_addr_a / in_addr_b  input  5  destination register of A / B.
REQ-006 SHALL have ports in_data_a / in_data_b  input  64  result data of A / B.
REQ-007 SHALL have port in_ready  output  1  queue can accept two results this cycle.
REQ-008 SHALL have port wb_hold  input  1  downstream stall; no drain while high.
REQ-009 SHALL have ports write_port_1 / write_port_2  output  5  register-file write addresses; 0 means no write.
REQ-010 SHALL have ports write_data_1 / write_data_2  output  64  register-file write data.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-012 SHALL have port err_overflow  output  1  sticky: a valid result was offered while in_ready was low.
REQ-013 SHALL have ports fwd_addr  input  5, fwd_hit  output  1, fwd_data  output  64  forwarding lookup (see Configuration).

Function
REQ-014 SHALL be a circular FIFO of DEPTH {addr, data} entries with head/tail pointers wrapping modulo DEPTH.
REQ-015 SHALL enqueue at the rising edge every offered result with in_valid=1, in_ready=1 and nonzero addr; A before B; zero-addr results are discarded without occupying an entry.
REQ-016 SHALL drive in_ready = (DEPTH - count >= 2), from registered count only; same-cycle drains do not raise it.
REQ-017 SHALL, on an offer while in_ready=0, discard the offer and set err_overflow to 1 at that edge.
REQ-018 SHALL, when wb_hold=0 and count>=1, drive write_port_1/write_data_1 from the head entry, combinationally from queue state.
REQ-019 SHALL, when wb_hold=0 and count>=2, drive write_port_2/write_data_2 from head+1 only if its addr differs from the head addr; otherwise write_port_2=0.
REQ-020 SHALL pop at the rising edge exactly the entries presented on nonzero write ports (0, 1 or 2).
REQ-021 SHALL drive write_port_1/2 = 0 and write_data_1/2 = 0 while wb_hold=1 or when the corresponding entry is absent.
REQ-022 SHALL update count = count + enqueued - popped in one edge when enqueue and drain coincide, including when count is full or empty.
REQ-023 SHALL give latency: result enqueued at edge N appears on a write port during cycle N+1 (if not held and at the head).
REQ-024 SHALL preserve per-register program order: a younger write never reaches the register file before an older write to the same register.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear head, tail and count to 0, err_overflow to 0, write ports/data to 0, fwd_hit/fwd_data to 0; in_ready=1 during and after reset.
REQ-026 SHALL discard all queued entries on reset mid-operation; entry contents need not be cleared.
REQ-027 SHALL resume accepting results on the first rising edge after reset_n goes high.

Configuration
REQ-028 SHALL, with macro WBQ_FORWARD_EN defined, drive fwd_hit=1 and fwd_data = data of the youngest valid queued entry whose addr equals fwd_addr (nonzero), combinationally; fwd_hit=0, fwd_data=0 otherwise.
REQ-029 SHALL, with WBQ_FORWARD_EN undefined, keep all ports present, tie fwd_hit=0 and fwd_data=0, and infer no comparison logic.

Verification
REQ-030 SHALL cover: reset, offer A={r5,0x11}, B={r6,0x22}, wb_hold=0 -> next cycle write_port_1=5/0x11, write_port_2=6/0x22, then count=0.
REQ-031 SHALL cover: A={r7,0xAA}, B={r7,0xBB} same cycle -> cycle 1 only write_port_1=7/0xAA, write_port_2=0; cycle 2 write_port_1=7/0xBB.
REQ-032 SHALL cover: wb_hold=1, offer 2 results/cycle for DEPTH/2 cycles -> count=8, in_ready=0; one further offer -> err_overflow=1, count stays 8.
REQ-033 SHALL cover: A={r0,0x55}, B={r3,0x66} -> only r3 enqueued, count=1.
REQ-034 SHALL cover: WBQ_FORWARD_EN, wb_hold=1, queue r9=0x1 then r9=0x2, fwd_addr=9 -> fwd_hit=1, fwd_data=0x2; fwd_addr=0 -> fwd_hit=0.
REQ-035 SHALL cover: reset_n low with count=5 mid-cycle -> count=0, write ports 0, in_ready=1 immediately, no stale write after release.

Source files
------------

// File: rtl/wb_queue_if.sv
// wb_queue_if -- bundle of all non-clock signals of the writeback queue.
//   master : producer/consumer side (execution results in, register-file writes out)
//   slave  : the queue itself
// Signals:
//   in_valid_a/b, in_addr_a/b, in_data_a/b : up to two results per cycle, A older than B
//   in_ready                               : room for two more results
//   wb_hold                                : downstream stall, no drain while high
//   write_port_1/2, write_data_1/2         : register-file writes, port 0 = no write
//   count                                  : occupied entries
//   err_overflow                           : sticky, result offered while not ready
//   fwd_addr, fwd_hit, fwd_data            : lookup of youngest queued value per register
interface wb_queue_if #(
    parameter int DEPTH = 8
);
    logic                     in_valid_a;
    logic                     in_valid_b;
    logic [4:0]               in_addr_a;
    logic [4:0]               in_addr_b;
    logic [63:0]              in_data_a;
    logic [63:0]              in_data_b;
    logic                     in_ready;
    logic                     wb_hold;
    logic [4:0]               write_port_1;
    logic [4:0]               write_port_2;
    logic [63:0]              write_data_1;
    logic [63:0]              write_data_2;
    logic [$clog2(DEPTH):0]   count;
    logic                     err_overflow;
    logic [4:0]               fwd_addr;
    logic                     fwd_hit;
    logic [63:0]              fwd_data;

    modport master (
        output in_valid_a, in_valid_b, in_addr_a, in_addr_b, in_data_a, in_data_b,
        output wb_hold, fwd_addr,
        input  in_ready, write_port_1, write_port_2, write_data_1, write_data_2,
        input  count, err_overflow, fwd_hit, fwd_data
    );

    modport slave (
        input  in_valid_a, in_valid_b, in_addr_a, in_addr_b, in_data_a, in_data_b,
        input  wb_hold, fwd_addr,
        output in_ready, write_port_1, write_port_2, write_data_1, write_data_2,
        output count, err_overflow, fwd_hit, fwd_data
    );
endinterface

// File: rtl/wb_queue.sv
// wb_queue -- dual-issue writeback queue between execution and the register file.
// Circular FIFO of DEPTH {addr, data} entries. Accepts up to two results per cycle
// (A before B), drains up to two per cycle onto the register-file write ports.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : wb_queue_if.slave (see interface header for signal list)
// Optional feature: define WBQ_FORWARD_EN to enable the fwd_addr lookup;
// otherwise fwd_hit/fwd_data are tied to 0.
module wb_queue #(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    wb_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    addr_q [DEPTH];
    logic [63:0]   data_q [DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [AW-1:0] head1, wr_idx_b;
    logic          acc_a, acc_b, pop1, pop2;
    logic [1:0]    n_enq, n_pop;

    // Readiness looks only at registered occupancy so it never depends on wb_hold.
    assign bus.in_ready = (cnt_q <= CW'(DEPTH - 2));

    // Zero-address results carry no register write; drop them without a slot.
    assign acc_a = bus.in_valid_a && bus.in_ready && (bus.in_addr_a != 5'd0);
    assign acc_b = bus.in_valid_b && bus.in_ready && (bus.in_addr_b != 5'd0);

    assign head1    = head_q + AW'(1);
    assign wr_idx_b = acc_a ? tail_q + AW'(1) : tail_q;

    // Second port only drains when it cannot overtake an older write to the same register.
    assign pop1 = !bus.wb_hold && (cnt_q != '0);
    assign pop2 = !bus.wb_hold && (cnt_q >= CW'(2)) && (addr_q[head1] != addr_q[head_q]);

    assign bus.write_port_1 = pop1 ? addr_q[head_q] : 5'd0;
    assign bus.write_data_1 = pop1 ? data_q[head_q] : 64'd0;
    assign bus.write_port_2 = pop2 ? addr_q[head1]  : 5'd0;
    assign bus.write_data_2 = pop2 ? data_q[head1]  : 64'd0;

    assign n_enq = {1'b0, acc_a} + {1'b0, acc_b};
    assign n_pop = {1'b0, pop1}  + {1'b0, pop2};

    always_comb begin
        head_d = head_q + AW'(n_pop);
        tail_d = tail_q + AW'(n_enq);
        cnt_d  = cnt_q + CW'(n_enq) - CW'(n_pop);
        err_d  = err_q | ((bus.in_valid_a | bus.in_valid_b) & ~bus.in_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (acc_a) begin
            addr_q[tail_q] <= bus.in_addr_a;
            data_q[tail_q] <= bus.in_data_a;
        end
        if (acc_b) begin
            addr_q[wr_idx_b] <= bus.in_addr_b;
            data_q[wr_idx_b] <= bus.in_data_b;
        end
    end

    assign bus.count        = cnt_q;
    assign bus.err_overflow = err_q;

`ifdef WBQ_FORWARD_EN
    logic [AW-1:0] fidx;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = 64'd0;
        fidx         = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q + AW'(i);
            if ((CW'(i) < cnt_q) && (bus.fwd_addr != 5'd0) && (addr_q[fidx] == bus.fwd_addr)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = data_q[fidx];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd   = ^bus.fwd_addr;
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = 64'd0;
`endif
endmodule
